n64_gs_flash_bridge: RTL and testbench
======================================

Name: n64_gs_flash_bridge

Overview:
- Parametrised next-generation bridge between the N64 cartridge Parallel Interface (PI) multiplexed AD bus and a parallel NOR flash (SST-type).
- Demultiplexes ALE_H/ALE_L address phases and decodes N_WIN configurable 12-bit address windows.
- Runs a read/write strobe state machine with an auto-incrementing burst offset, and drives flash address, CE, OE and (optionally) WE.
- Sits between the cartridge edge connector and the flash device on the Gameshark board.

Parameters:
FLASH_AW, 19, flash word-address width; sst = ad_store[FLASH_AW:1] + offset
INC_W, 13, burst offset counter width
SYNC_STAGES, 2, synchroniser flops per PI control input (min 2)
N_WIN, 2, number of decoded address windows (1..8)
WIN_BASES, {12'h10C,12'h100}, packed N_WIN*12 bits; window i = bits [12i+11:12i], matched against ad_store[31:20]

Ports:
clk  in  1  system clock
cold_reset  in  1  asynchronous active-low reset
ad  in  16  PI multiplexed address/data bus
aleh  in  1  PI ALE_H
alel  in  1  PI ALE_L
read  in  1  PI read strobe, active-low
write  in  1  PI write strobe, active-low
sst  out  FLASH_AW  flash address
sst_ce  out  1  flash chip enable, active-low
sst_oe  out  1  flash output enable, active-low
sst_we  out  1  flash write enable, active-low
win_hit  out  N_WIN  registered one-hot window match
busy  out  1  high while FSM is not IDLE

Behaviour:
- Reset (async, cold_reset=0): sst=0, sst_ce=sst_oe=sst_we=1, win_hit=0, busy=0, ad_store=0, offset=0, FSM=IDLE. Read/write sync chains preset to 1; ALE chains cleared to 0. Outputs go inactive immediately on reset assertion, including mid-cycle.
- Synchronisation: aleh, alel, read and write each pass through SYNC_STAGES flops. Edges are detected on the last two synchronised samples.
- Address latch:
  - alel_s=1 and aleh_s=0: ad_store[15:0] <= ad and offset <= 0.
  - alel_s=1 and aleh_s=1: ad_store[31:16] <= ad.
  - ad is sampled raw, since the PI holds ad stable while ALE is asserted.
- Window decode: win_hit[i] = (ad_store[31:20] == WIN_BASES[i]), registered. Hit = |win_hit. Overlapping bases are legal; any hit qualifies.
- Address arithmetic: sst = ad_store[FLASH_AW:1] + zero-extended offset, truncated to FLASH_AW bits (wraps modulo 2^FLASH_AW). offset wraps modulo 2^INC_W.
- FSM states: IDLE, RD_ACTIVE, WR_ACTIVE, RECOVER.
  - IDLE -> RD_ACTIVE on read falling edge with hit. Drive sst, sst_ce=0, sst_oe=0.
  - IDLE -> WR_ACTIVE on write falling edge with hit. Drive sst, sst_ce=0, sst_we=0 (see feature).
  - RD_ACTIVE/WR_ACTIVE -> RECOVER on the matching strobe rising edge. All enables go to 1 and offset increments.
  - RECOVER -> IDLE after 1 cycle.
  - A falling edge with no hit leaves the FSM in IDLE. offset still increments on that strobe's rising edge, so bursts crossing into non-window space remain consistent.
- Latency: pad strobe falling edge to sst_oe/sst_we low = SYNC_STAGES+2 clk. Rising edge to deassert = SYNC_STAGES+2 clk.
- Boundary conditions:
  - Read and write falling edges in the same cycle: read wins. Write is ignored until it returns high.
  - Strobe edges in RECOVER are ignored.
  - ALE asserted (alel_s=1) during RD_ACTIVE/WR_ACTIVE aborts: all enables go to 1 next cycle, FSM -> IDLE, offset is not incremented, and the latch is applied.
  - offset at 2^INC_W-1 plus increment -> 0.

Optional Feature:
SST_WRITE_EN:
- Defined: WR_ACTIVE drives sst_we=0 and sst_ce=0 for flash programming.
- Undefined: sst_we is tied to 1, and WR_ACTIVE asserts neither CE nor WE. WR_ACTIVE still sequences and still increments offset, so addressing matches the PI view (write-protected cartridge).

Decomposition:
- Package n64_gs_pkg:
  - FSM state enum.
  - AD_W=16 and WIN_TAG_W=12.
  - Default window constants GS_WIN_ROM=12'h100 and GS_WIN_ALT=12'h10C.
- Sub-module n64_gs_sync: SYNC_STAGES-deep synchroniser with a reset-value parameter and rise/fall pulse outputs. Instantiated 4x.

Test Plan:
- ALE_H ad=16'h1000, ALE_L ad=16'h0100, read pulse -> sst=19'h00080, sst_ce=sst_oe=0 SYNC_STAGES+2 clk after fall; win_hit=2'b01.
- Same latch, then 4 read pulses -> sst = 0x80, 0x81, 0x82, 0x83. A new ALE_L resets the sequence to 0x80.
- ad_store=32'h2000_0000 and read pulse -> no enables asserted, busy stays 0; offset still increments.
- SST_WRITE_EN defined, write pulse in window 32'h10C0_0002 -> sst=1, sst_ce=sst_we=0, sst_oe=1. Undefined -> all enables stay 1.
- read and write fall in the same clk -> RD_ACTIVE only, sst_we=1. Assert cold_reset=0 mid-read -> all enables 1 asynchronously, sst=0.
- ad_store[FLASH_AW:1]=all ones, offset=1 -> sst=0 (wrap); ALE_L during RD_ACTIVE -> sst_oe=1 next clk, FSM IDLE.

Source files
------------

// File: rtl/n64_gs_pkg.sv
// Shared types and constants for the N64 Gameshark PI-to-NOR-flash bridge.
package n64_gs_pkg;

    localparam int AD_W      = 16;
    localparam int WIN_TAG_W = 12;

    // Default decode windows (matched against ad_store[31:20])
    localparam logic [WIN_TAG_W-1:0] GS_WIN_ROM = 12'h100;
    localparam logic [WIN_TAG_W-1:0] GS_WIN_ALT = 12'h10C;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_ACTIVE = 2'd1,
        ST_WR_ACTIVE = 2'd2,
        ST_RECOVER   = 2'd3
    } gs_state_e;

endpackage

// File: rtl/n64_gs_sync.sv
// Multi-flop synchroniser for one PI control line. Produces the synchronised
// level plus registered single-cycle rise/fall pulses derived from the last
// synchronised sample and its one-cycle history.
module n64_gs_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic              rise_q;
    logic              fall_q;

    // Shift the raw input through the chain and register edge pulses
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[STAGES-1] & hist_q;
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/n64_gs_flash_bridge.sv
// N64 PI multiplexed AD bus to SST parallel NOR flash bridge.
// Latches the 32-bit PI address from ALE_H/ALE_L phases, decodes N_WIN
// address windows and sequences flash CE/OE/WE from the PI strobes with an
// auto-incrementing burst offset.
// Build option: define SST_WRITE_EN to let PI writes drive flash CE/WE;
// otherwise the flash is write-protected (sst_we held high).
module n64_gs_flash_bridge
    import n64_gs_pkg::*;
#(
    parameter int FLASH_AW    = 19,
    parameter int INC_W       = 13,
    parameter int SYNC_STAGES = 2,
    parameter int N_WIN       = 2,
    parameter logic [N_WIN*WIN_TAG_W-1:0] WIN_BASES = {GS_WIN_ALT, GS_WIN_ROM}
) (
    input  logic                clk,
    input  logic                cold_reset,
    input  logic [AD_W-1:0]     ad,
    input  logic                aleh,
    input  logic                alel,
    input  logic                read,
    input  logic                write,
    output logic [FLASH_AW-1:0] sst,
    output logic                sst_ce,
    output logic                sst_oe,
    output logic                sst_we,
    output logic [N_WIN-1:0]    win_hit,
    output logic                busy
);

    logic aleh_s, alel_s;
    logic rd_rise, rd_fall, wr_rise, wr_fall;
    logic rd_level_unused, wr_level_unused;
    logic aleh_rise_unused, aleh_fall_unused, alel_rise_unused, alel_fall_unused;

    n64_gs_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_aleh (
        .clk(clk), .rst_ni(cold_reset), .d_i(aleh),
        .q_o(aleh_s), .rise_o(aleh_rise_unused), .fall_o(aleh_fall_unused));
    n64_gs_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_alel (
        .clk(clk), .rst_ni(cold_reset), .d_i(alel),
        .q_o(alel_s), .rise_o(alel_rise_unused), .fall_o(alel_fall_unused));
    n64_gs_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_read (
        .clk(clk), .rst_ni(cold_reset), .d_i(read),
        .q_o(rd_level_unused), .rise_o(rd_rise), .fall_o(rd_fall));
    n64_gs_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_write (
        .clk(clk), .rst_ni(cold_reset), .d_i(write),
        .q_o(wr_level_unused), .rise_o(wr_rise), .fall_o(wr_fall));

    gs_state_e             state_q, state_d;
    logic [31:0]           ad_store_q, ad_store_d;
    logic [INC_W-1:0]      offset_q, offset_d;
    logic [FLASH_AW-1:0]   sst_q, sst_d;
    logic                  ce_q, ce_d;
    logic                  oe_q, oe_d;
    logic                  miss_rd_q, miss_rd_d;
    logic                  miss_wr_q, miss_wr_d;
    logic [N_WIN-1:0]      win_hit_q, win_hit_d;
    logic [FLASH_AW-1:0]   flash_addr;
    logic                  hit;
    logic                  in_access;

    // One comparator per window; overlapping bases simply set several bits
    for (genvar gi = 0; gi < N_WIN; gi++) begin : g_win
        assign win_hit_d[gi] = (ad_store_q[31:20] == WIN_BASES[gi*WIN_TAG_W +: WIN_TAG_W]);
    end

    assign hit        = |win_hit_q;
    assign flash_addr = ad_store_q[FLASH_AW:1] + FLASH_AW'(offset_q);
    assign in_access  = (state_q == ST_RD_ACTIVE) || (state_q == ST_WR_ACTIVE);

`ifdef SST_WRITE_EN
    logic we_q, we_d;
`endif

    // Next-state, address latch, burst offset and flash strobe decisions
    always_comb begin
        state_d    = state_q;
        ad_store_d = ad_store_q;
        offset_d   = offset_q;
        sst_d      = sst_q;
        ce_d       = ce_q;
        oe_d       = oe_q;
        miss_rd_d  = miss_rd_q;
        miss_wr_d  = miss_wr_q;
`ifdef SST_WRITE_EN
        we_d       = we_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Read wins when both strobes fall together
                if (rd_fall) begin
                    if (hit) begin
                        state_d = ST_RD_ACTIVE;
                        sst_d   = flash_addr;
                        ce_d    = 1'b0;
                        oe_d    = 1'b0;
                    end else begin
                        miss_rd_d = 1'b1;
                    end
                end else if (wr_fall) begin
                    if (hit) begin
                        state_d = ST_WR_ACTIVE;
                        sst_d   = flash_addr;
`ifdef SST_WRITE_EN
                        ce_d    = 1'b0;
                        we_d    = 1'b0;
`endif
                    end else begin
                        miss_wr_d = 1'b1;
                    end
                end
                // Out-of-window accesses still advance the burst offset
                if (miss_rd_q && rd_rise) begin
                    offset_d  = offset_q + INC_W'(1);
                    miss_rd_d = 1'b0;
                end else if (miss_wr_q && wr_rise) begin
                    offset_d  = offset_q + INC_W'(1);
                    miss_wr_d = 1'b0;
                end
            end
            ST_RD_ACTIVE: begin
                if (rd_rise) begin
                    state_d  = ST_RECOVER;
                    ce_d     = 1'b1;
                    oe_d     = 1'b1;
                    offset_d = offset_q + INC_W'(1);
                end
            end
            ST_WR_ACTIVE: begin
                if (wr_rise) begin
                    state_d  = ST_RECOVER;
                    ce_d     = 1'b1;
                    oe_d     = 1'b1;
`ifdef SST_WRITE_EN
                    we_d     = 1'b1;
`endif
                    offset_d = offset_q + INC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new address phase during an access aborts it without advancing
        if (alel_s && in_access) begin
            state_d  = ST_IDLE;
            ce_d     = 1'b1;
            oe_d     = 1'b1;
`ifdef SST_WRITE_EN
            we_d     = 1'b1;
`endif
            offset_d = offset_q;
        end

        // Address latch has final say over ad_store and the offset
        if (alel_s) begin
            if (aleh_s) begin
                ad_store_d[31:16] = ad;
            end else begin
                ad_store_d[15:0] = ad;
                offset_d         = '0;
            end
        end
    end

    // State, address and registered flash outputs
    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
            state_q    <= ST_IDLE;
            ad_store_q <= '0;
            offset_q   <= '0;
            sst_q      <= '0;
            ce_q       <= 1'b1;
            oe_q       <= 1'b1;
            miss_rd_q  <= 1'b0;
            miss_wr_q  <= 1'b0;
            win_hit_q  <= '0;
        end else begin
            state_q    <= state_d;
            ad_store_q <= ad_store_d;
            offset_q   <= offset_d;
            sst_q      <= sst_d;
            ce_q       <= ce_d;
            oe_q       <= oe_d;
            miss_rd_q  <= miss_rd_d;
            miss_wr_q  <= miss_wr_d;
            win_hit_q  <= win_hit_d;
        end
    end

`ifdef SST_WRITE_EN
    // Flash write enable register, only present when programming is allowed
    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
            we_q <= 1'b1;
        end else begin
            we_q <= we_d;
        end
    end
    assign sst_we = we_q;
`else
    assign sst_we = 1'b1;
`endif

    assign sst     = sst_q;
    assign sst_ce  = ce_q;
    assign sst_oe  = oe_q;
    assign win_hit = win_hit_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_n64_gs_flash_bridge.sv
// Directed, table-driven bench for n64_gs_flash_bridge. Expectations for
// PI write cycles follow the SST_WRITE_EN build option.
module tb_n64_gs_flash_bridge;

    localparam int STAGES = 2;

`ifdef SST_WRITE_EN
    localparam logic WR_EN_EXP = 1'b0;
`else
    localparam logic WR_EN_EXP = 1'b1;
`endif

    logic        clk;
    logic        cold_reset;
    logic [15:0] ad;
    logic        aleh, alel, read, write;
    logic [18:0] sst;
    logic        sst_ce, sst_oe, sst_we;
    logic [1:0]  win_hit;
    logic        busy;

    int total = 0;
    int bad   = 0;

    n64_gs_flash_bridge #(
        .FLASH_AW(19), .INC_W(13), .SYNC_STAGES(STAGES), .N_WIN(2),
        .WIN_BASES({12'h10C, 12'h100})
    ) dut (
        .clk(clk), .cold_reset(cold_reset), .ad(ad), .aleh(aleh), .alel(alel),
        .read(read), .write(write), .sst(sst), .sst_ce(sst_ce), .sst_oe(sst_oe),
        .sst_we(sst_we), .win_hit(win_hit), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          mode;     // 0: no latch, 1: full address, 2: high half only
        logic [15:0] hi;
        logic [15:0] lo;
        logic        is_wr;
        logic        chk_sst;
        logic [18:0] exp_sst;
        logic [1:0]  exp_win;
        logic        exp_ce;
        logic        exp_oe;
        logic        exp_we;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic latch(input int mode, input logic [15:0] hi, input logic [15:0] lo);
        if (mode == 0) return;
        @(negedge clk);
        alel = 1'b1; aleh = 1'b1; ad = hi;
        repeat (6) @(negedge clk);
        if (mode == 1) begin
            aleh = 1'b0;
            repeat (6) @(negedge clk);
            ad = lo;
            repeat (6) @(negedge clk);
            alel = 1'b0;
        end else begin
            alel = 1'b0; aleh = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    // One PI strobe pulse; returns outputs sampled SYNC_STAGES+2 clocks after the fall
    task automatic strobe(input logic is_wr, output logic [18:0] o_sst, output logic o_ce,
                          output logic o_oe, output logic o_we, output logic o_busy,
                          output logic [1:0] o_win);
        @(negedge clk);
        if (is_wr) write = 1'b0; else read = 1'b0;
        repeat (STAGES + 1) @(negedge clk);
        check("early_ce", 32'(sst_ce), 32'd1);
        check("early_oe", 32'(sst_oe), 32'd1);
        check("early_we", 32'(sst_we), 32'd1);
        @(negedge clk);
        o_sst = sst; o_ce = sst_ce; o_oe = sst_oe; o_we = sst_we; o_busy = busy; o_win = win_hit;
        repeat (3) @(negedge clk);
        if (is_wr) write = 1'b1; else read = 1'b1;
        repeat (STAGES + 2) @(negedge clk);
        check("release_ce", 32'(sst_ce), 32'd1);
        check("release_oe", 32'(sst_oe), 32'd1);
        check("release_we", 32'(sst_we), 32'd1);
        repeat (3) @(negedge clk);
        check("release_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [18:0] r_sst;
        logic        r_ce, r_oe, r_we, r_busy;
        logic [1:0]  r_win;

        //           mode hi       lo       wr    chk   sst        win    ce         oe    we         busy
        vecs[0] = '{1, 16'h1000, 16'h0100, 1'b0, 1'b1, 19'h00080, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[1] = '{0, 16'h0000, 16'h0000, 1'b0, 1'b1, 19'h00081, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[2] = '{0, 16'h0000, 16'h0000, 1'b0, 1'b1, 19'h00082, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[3] = '{0, 16'h0000, 16'h0000, 1'b0, 1'b1, 19'h00083, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[4] = '{1, 16'h1000, 16'h0100, 1'b0, 1'b1, 19'h00080, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[5] = '{1, 16'h2000, 16'h0000, 1'b0, 1'b0, 19'h00000, 2'b00, 1'b1,      1'b1, 1'b1,      1'b0};
        vecs[6] = '{2, 16'h1000, 16'h0000, 1'b0, 1'b1, 19'h00001, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[7] = '{1, 16'h10C0, 16'h0002, 1'b1, 1'b1, 19'h00001, 2'b10, WR_EN_EXP, 1'b1, WR_EN_EXP, 1'b1};
        vecs[8] = '{1, 16'h100F, 16'hFFFE, 1'b0, 1'b1, 19'h7FFFF, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};
        vecs[9] = '{0, 16'h0000, 16'h0000, 1'b0, 1'b1, 19'h00000, 2'b01, 1'b0,      1'b0, 1'b1,      1'b1};

        cold_reset = 1'b1; ad = '0; aleh = 1'b0; alel = 1'b0; read = 1'b1; write = 1'b1;
        #2 cold_reset = 1'b0;
        #1;
        check("rst_sst", 32'(sst), 32'd0);
        check("rst_ce", 32'(sst_ce), 32'd1);
        check("rst_oe", 32'(sst_oe), 32'd1);
        check("rst_we", 32'(sst_we), 32'd1);
        check("rst_win", 32'(win_hit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        cold_reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            latch(vecs[i].mode, vecs[i].hi, vecs[i].lo);
            strobe(vecs[i].is_wr, r_sst, r_ce, r_oe, r_we, r_busy, r_win);
            if (vecs[i].chk_sst) check($sformatf("v%0d_sst", i), 32'(r_sst), 32'(vecs[i].exp_sst));
            check($sformatf("v%0d_ce", i), 32'(r_ce), 32'(vecs[i].exp_ce));
            check($sformatf("v%0d_oe", i), 32'(r_oe), 32'(vecs[i].exp_oe));
            check($sformatf("v%0d_we", i), 32'(r_we), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_busy", i), 32'(r_busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d_win", i), 32'(r_win), 32'(vecs[i].exp_win));
            $display("vec %0d: wr=%0d sst=%h ce=%0d oe=%0d we=%0d busy=%0d win=%b",
                     i, vecs[i].is_wr, r_sst, r_ce, r_oe, r_we, r_busy, r_win);
        end

        // Read and write fall together: read access only
        latch(1, 16'h1000, 16'h0100);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        repeat (STAGES + 2) @(negedge clk);
        check("both_sst", 32'(sst), 32'h80);
        check("both_oe", 32'(sst_oe), 32'd0);
        check("both_ce", 32'(sst_ce), 32'd0);
        check("both_we", 32'(sst_we), 32'd1);
        check("both_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        read = 1'b1; write = 1'b1;
        repeat (10) @(negedge clk);
        check("both_after_busy", 32'(busy), 32'd0);
        check("both_after_we", 32'(sst_we), 32'd1);
        $display("seq both: sst=%h busy=%0d we=%0d", sst, busy, sst_we);

        // ALE_L during an active read aborts it the cycle after alel_s rises
        latch(1, 16'h1000, 16'h0100);
        @(negedge clk);
        read = 1'b0;
        repeat (STAGES + 2) @(negedge clk);
        check("abort_pre_oe", 32'(sst_oe), 32'd0);
        alel = 1'b1; aleh = 1'b0; ad = 16'h0200;
        repeat (STAGES) @(negedge clk);
        check("abort_hold_oe", 32'(sst_oe), 32'd0);
        @(negedge clk);
        check("abort_oe", 32'(sst_oe), 32'd1);
        check("abort_ce", 32'(sst_ce), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        read = 1'b1;
        repeat (6) @(negedge clk);
        alel = 1'b0;
        repeat (6) @(negedge clk);
        strobe(1'b0, r_sst, r_ce, r_oe, r_we, r_busy, r_win);
        check("abort_next_sst", 32'(r_sst), 32'h100);
        check("abort_next_oe", 32'(r_oe), 32'd0);
        $display("seq abort: next sst=%h oe=%0d", r_sst, r_oe);

        // Reset asserted mid-read drops everything immediately
        @(negedge clk);
        read = 1'b0;
        repeat (STAGES + 2) @(negedge clk);
        check("mid_pre_sst", 32'(sst), 32'h101);
        check("mid_pre_oe", 32'(sst_oe), 32'd0);
        @(posedge clk);
        #2 cold_reset = 1'b0;
        #1;
        check("mid_rst_ce", 32'(sst_ce), 32'd1);
        check("mid_rst_oe", 32'(sst_oe), 32'd1);
        check("mid_rst_we", 32'(sst_we), 32'd1);
        check("mid_rst_sst", 32'(sst), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_win", 32'(win_hit), 32'd0);
        $display("seq midreset: sst=%h ce=%0d oe=%0d", sst, sst_ce, sst_oe);
        @(negedge clk);
        cold_reset = 1'b1; read = 1'b1;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
